// File: rtl/stopwatch_bcd_display.sv
// stopwatch_bcd_display: BCD up/down stopwatch with lap hold and a multiplexed active-low 7-segment display.
module stopwatch_bcd_display #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int SCAN_DIV   = 4000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_start,
    input  logic                    btn_clear,
    input  logic                    btn_lap,
    input  logic                    mode_down,
    input  logic [4*NUM_DIGITS-1:0] preload,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    running,
    output logic                    done
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   count, count_nx, lap_reg, lap_nx, incd, decd, pre_bcd, disp;
    logic           lap_hold, lap_hold_nx, down_mode, down_nx;
    logic [TW-1:0]  tick_cnt, tick_nx;
    logic [SW-1:0]  scan_cnt;
    logic [IW-1:0]  idx, idx_nx;
    logic [2:0]     s_start, s_clear, s_lap;
    logic           start_e, clear_e, lap_e, tick, hit_zero, scan_wrap, blank;
    logic [3:0]     digit;
    logic [6:0]     seg_nx;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: dec7 = 7'b1000000;
            4'd1: dec7 = 7'b1111001;
            4'd2: dec7 = 7'b0100100;
            4'd3: dec7 = 7'b0110000;
            4'd4: dec7 = 7'b0011001;
            4'd5: dec7 = 7'b0010010;
            4'd6: dec7 = 7'b0000010;
            4'd7: dec7 = 7'b1111000;
            4'd8: dec7 = 7'b0000000;
            4'd9: dec7 = 7'b0010000;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    assign start_e   = s_start[1] & ~s_start[2];
    assign clear_e   = s_clear[1] & ~s_clear[2];
    assign lap_e     = s_lap[1] & ~s_lap[2];
    assign tick      = (state == RUN) && (tick_cnt == TW'(TICK_DIV - 1));
    assign hit_zero  = tick && down_mode && (decd == '0);
    assign running   = (state == RUN);
    assign done      = (state == DONE);
    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
    assign idx_nx    = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    assign disp      = lap_hold ? lap_reg : count;
    assign digit     = disp[{idx_nx, 2'b00} +: 4];
    assign blank     = BLANK_LZ && (idx_nx != '0) && ((disp >> {idx_nx, 2'b00}) == '0);
    assign seg_nx    = blank ? 7'h7F : dec7(digit);

    // Ripple carry/borrow across digits; preload digits above 9 saturate to 9.
    always_comb begin
        logic cy, bw;
        logic [3:0] d;
        cy = 1'b1;
        bw = 1'b1;
        d = '0;
        incd = '0;
        decd = '0;
        pre_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = count[4*i +: 4];
            incd[4*i +: 4] = cy ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
            decd[4*i +: 4] = bw ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
            cy = cy & (d == 4'd9);
            bw = bw & (d == 4'd0);
            pre_bcd[4*i +: 4] = (preload[4*i +: 4] > 4'd9) ? 4'd9 : preload[4*i +: 4];
        end
    end

    // Reaching zero while counting down wins over a simultaneous stop request.
    always_comb begin
        state_nx    = hit_zero ? DONE : state;
        count_nx    = tick ? (down_mode ? decd : incd) : count;
        lap_nx      = lap_reg;
        lap_hold_nx = lap_hold;
        down_nx     = down_mode;
        tick_nx     = (state == RUN) ? (tick ? '0 : tick_cnt + 1'b1) : tick_cnt;
        if (clear_e) begin
            state_nx    = IDLE;
            down_nx     = mode_down;
            count_nx    = mode_down ? pre_bcd : '0;
            lap_hold_nx = 1'b0;
            tick_nx     = '0;
        end else if (start_e) begin
            state_nx = (state == IDLE)  ? ((down_mode && count == '0) ? DONE : RUN) :
                       (state == PAUSE) ? RUN :
                       (state == RUN && !hit_zero) ? PAUSE : state_nx;
        end else if (lap_e && (state == RUN || state == PAUSE)) begin
            lap_hold_nx = !lap_hold;
            lap_nx      = lap_hold ? lap_reg : count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_start   <= '0;
            s_clear   <= '0;
            s_lap     <= '0;
            state     <= IDLE;
            count     <= '0;
            lap_reg   <= '0;
            lap_hold  <= 1'b0;
            down_mode <= 1'b0;
            tick_cnt  <= '0;
            scan_cnt  <= '0;
            idx       <= '0;
            seg       <= 7'h7F;
            anode     <= '1;
        end else begin
            s_start   <= {s_start[1:0], btn_start};
            s_clear   <= {s_clear[1:0], btn_clear};
            s_lap     <= {s_lap[1:0], btn_lap};
            state     <= state_nx;
            count     <= count_nx;
            lap_reg   <= lap_nx;
            lap_hold  <= lap_hold_nx;
            down_mode <= down_nx;
            tick_cnt  <= tick_nx;
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap) begin
                idx   <= idx_nx;
                seg   <= seg_nx;
                anode <= ~(NUM_DIGITS'(1) << idx_nx);
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_bcd_display.sv
// tb_stopwatch_bcd_display: directed plus random stimulus against a decimal-arithmetic model of the stopwatch.
module tb_stopwatch_bcd_display;
    localparam int ND = 4, TD = 4, SD = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        btn_start = 0, btn_clear = 0, btn_lap = 0, mode_down = 0;
    logic [15:0] preload = '0;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        running, done;

    int vectors = 0, miscompares = 0;

    int m_state, m_count, m_lap, m_div, m_scan, m_idx;
    bit m_hold, m_down;
    logic [2:0] hs, hc, hl;
    logic [6:0] m_seg;
    logic [3:0] m_anode;

    stopwatch_bcd_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .mode_down(mode_down), .preload(preload), .seg(seg), .anode(anode), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic int p10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r *= 10;
        return r;
    endfunction

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic int clamp_dec(input logic [15:0] p);
        int r = 0;
        for (int k = 0; k < ND; k++) r += ((p[4*k +: 4] > 9) ? 9 : int'(p[4*k +: 4])) * p10(k);
        return r;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_count = 0; m_lap = 0; m_div = 0; m_scan = 0; m_idx = 0;
        m_hold = 0; m_down = 0; hs = '0; hc = '0; hl = '0; m_seg = 7'h7F; m_anode = 4'hF;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("running", 32'(running), 32'(m_state == S_RUN));
        chk("done", 32'(done), 32'(m_state == S_DONE));
        chk("seg", 32'(seg), 32'(m_seg));
        chk("anode", 32'(anode), 32'(m_anode));
        chk("count", 32'(dut.count), 32'(bcd(m_count)));
    endtask

    task automatic step();
        int disp, old;
        bit ts, tc, tl, tick, zero;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            disp = m_hold ? m_lap : m_count;
            ts = hs[1] & ~hs[2]; tc = hc[1] & ~hc[2]; tl = hl[1] & ~hl[2];
            hs = {hs[1:0], btn_start}; hc = {hc[1:0], btn_clear}; hl = {hl[1:0], btn_lap};
            if (m_scan == SD - 1) begin
                m_scan = 0;
                m_idx = (m_idx + 1) % ND;
                m_seg = (m_idx > 0 && disp < p10(m_idx)) ? 7'h7F : seg7((disp / p10(m_idx)) % 10);
                m_anode = ~(4'b1 << m_idx);
            end else m_scan++;
            tick = (m_state == S_RUN) && (m_div == TD - 1);
            if (m_state == S_RUN) m_div = tick ? 0 : m_div + 1;
            old = m_count;
            zero = 0;
            if (tick) begin
                if (m_down) begin m_count--; zero = (m_count == 0); end
                else m_count = (m_count + 1) % p10(ND);
            end
            if (tc) begin
                m_state = S_IDLE; m_down = mode_down; m_count = mode_down ? clamp_dec(preload) : 0;
                m_hold = 0; m_div = 0;
            end else begin
                if (zero) m_state = S_DONE;
                if (ts) begin
                    if (m_state == S_IDLE) m_state = (m_down && m_count == 0) ? S_DONE : S_RUN;
                    else if (m_state == S_PAUSE) m_state = S_RUN;
                    else if (m_state == S_RUN) m_state = S_PAUSE;
                end else if (tl && (m_state == S_RUN || m_state == S_PAUSE)) begin
                    if (!m_hold) m_lap = old;
                    m_hold = !m_hold;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input bit s, input bit c, input bit l);
        btn_start = s; btn_clear = c; btn_lap = l;
        steps(3);
        btn_start = 0; btn_clear = 0; btn_lap = 0;
        steps(3);
    endtask

    initial begin
        model_reset();
        steps(3);
        rst_n = 1'b1;
        steps(20);

        mode_down = 0;
        press(0, 1, 0);
        press(1, 0, 0);
        for (int i = 0; i < 100 && m_count != 10; i++) step();
        chk("up_count_10", 32'(dut.count), 32'h0010);
        press(1, 0, 0);
        steps(13);
        press(1, 0, 0);
        steps(17);

        press(0, 1, 0);
        press(1, 0, 0);
        for (int i = 0; i < 41000 && m_count != 9999; i++) step();
        chk("wrap_9999", 32'(dut.count), 32'h9999);
        for (int i = 0; i < 10 && m_count != 0; i++) step();
        chk("wrap_0000", 32'(dut.count), 32'h0000);
        chk("wrap_running", 32'(running), 32'h1);
        steps(9);

        preload = 16'h0102; mode_down = 1;
        press(0, 1, 0);
        chk("down_preload", 32'(dut.count), 32'h0102);
        press(1, 0, 0);
        for (int i = 0; i < 1000 && m_state != S_DONE; i++) step();
        chk("down_done", 32'(done), 32'h1);
        chk("down_zero", 32'(dut.count), 32'h0000);
        press(1, 0, 0);
        chk("done_ignores_start", 32'(done), 32'h1);

        mode_down = 0;
        press(0, 1, 0);
        press(1, 0, 0);
        for (int i = 0; i < 100 && m_count != 5; i++) step();
        chk("lap_at5", 32'(dut.count), 32'h0005);
        press(0, 0, 1);
        for (int i = 0; i < 100 && m_count != 9; i++) step();
        chk("lap_hold_on", 32'(dut.lap_hold), 32'h1);
        press(0, 0, 1);
        steps(10);
        press(1, 0, 1);
        press(0, 0, 1);
        steps(8);
        press(0, 1, 0);
        chk("clear_releases_lap", 32'(dut.lap_hold), 32'h0);

        press(1, 0, 0);
        steps(9);
        press(1, 1, 0);
        chk("clear_start_idle", 32'(running), 32'h0);
        chk("clear_start_count", 32'(dut.count), 32'h0000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 40) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
            if ($urandom_range(0, 30) == 0) begin
                mode_down = 1'($urandom);
                preload = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            end
            step();
        end
        btn_start = 0; btn_clear = 0; btn_lap = 0; mode_down = 0;
        steps(4);

        press(0, 1, 0);
        press(1, 0, 0);
        steps(10);
        chk("pre_reset_running", 32'(running), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        steps(2);
        rst_n = 1'b1;
        steps(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
